// File: rtl/control_sequencer.sv
// Fetch/execute sequencer for the 16-bit bus processor: owns the IR and drives every datapath strobe.
// Optional HALT_INSTR_EN: opcode F enters an absorbing HALT state (otherwise it runs as a NOP).
module control_sequencer #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [DATA_W-1:0]   instr,
  output logic [DATA_W-1:0]   ir,
  output logic                pc_in,
  output logic                done,
  output logic                ext_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                a_in,
  output logic                g_in,
  output logic                g_out,
  output logic [1:0]          alu_op,
  output logic                busy,
  output logic                halted
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_T1    = 3'd2;
  localparam logic [2:0] S_T2    = 3'd3;
  localparam logic [2:0] S_T3    = 3'd4;
`ifdef HALT_INSTR_EN
  localparam logic [2:0] S_HALT  = 3'd5;
`endif

  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
`ifdef HALT_INSTR_EN
  localparam logic [3:0] OP_HALT = 4'hF;
`endif

  logic [2:0]          state;
  logic [2:0]          state_next;
  logic [3:0]          opcode;
  logic [NUM_REGS-1:0] rx_sel;
  logic [NUM_REGS-1:0] ry_sel;

  assign opcode = ir[15:12];
  assign rx_sel = NUM_REGS'(1) << ir[11:10];
  assign ry_sel = NUM_REGS'(1) << ir[9:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH)
        ir <= instr;
    end
  end

  // Every instruction-completing step returns to FETCH directly so back-to-back instructions have no bubble.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = run ? S_FETCH : S_IDLE;
      S_FETCH: state_next = S_T1;
      S_T1: begin
        if (opcode == OP_ADD || opcode == OP_SUB)
          state_next = S_T2;
`ifdef HALT_INSTR_EN
        else if (opcode == OP_HALT)
          state_next = S_HALT;
`endif
        else
          state_next = run ? S_FETCH : S_IDLE;
      end
      S_T2:    state_next = S_T3;
      S_T3:    state_next = run ? S_FETCH : S_IDLE;
`ifdef HALT_INSTR_EN
      S_HALT:  state_next = S_HALT;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_in   = 1'b0;
    done    = 1'b0;
    ext_out = 1'b0;
    reg_in  = '0;
    reg_out = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    alu_op  = 2'b00;
    busy    = (state != S_IDLE);
    halted  = 1'b0;
`ifdef HALT_INSTR_EN
    halted  = (state == S_HALT);
`endif
    case (state)
      S_T1: begin
        case (opcode)
          OP_LOAD: begin
            ext_out = 1'b1;
            reg_in  = rx_sel;
            done    = 1'b1;
          end
          OP_MOV: begin
            reg_out = ry_sel;
            reg_in  = rx_sel;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            reg_out = rx_sel;
            a_in    = 1'b1;
          end
          OP_JMP: begin
            ext_out = 1'b1;
            pc_in   = 1'b1;
            done    = 1'b1;
          end
`ifdef HALT_INSTR_EN
          OP_HALT: done = 1'b0;
`endif
          default: done = 1'b1;
        endcase
      end
      S_T2: begin
        reg_out = ry_sel;
        g_in    = 1'b1;
        alu_op  = (opcode == OP_SUB) ? 2'b01 : 2'b00;
      end
      S_T3: begin
        g_out  = 1'b1;
        reg_in = rx_sel;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a program memory and PC model feed instructions,
// and per-cycle expected strobe vectors are queued up front and checked as the DUT steps.
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic [15:0] ir;
  logic        pc_in, done, ext_out, a_in, g_in, g_out, busy, halted;
  logic [3:0]  reg_in, reg_out;
  logic [1:0]  alu_op;

  logic [15:0] mem [256];
  logic [7:0]  pc;
  logic [7:0]  pcStart;
  logic [17:0] obsVec;

  typedef struct {
    logic [17:0] vec;
    logic        chkIr;
    logic [15:0] irExp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   nCompared;
  int   nMismatched;

  control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .ir(ir),
    .pc_in(pc_in), .done(done), .ext_out(ext_out), .reg_in(reg_in),
    .reg_out(reg_out), .a_in(a_in), .g_in(g_in), .g_out(g_out),
    .alu_op(alu_op), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr  = mem[pc];
  assign obsVec = {pc_in, done, ext_out, reg_in, reg_out, a_in, g_in, g_out, alu_op, busy, halted};

  // Program counter as the datapath sees it: updated on the falling edge from done/pc_in.
  always @(negedge clk) begin
    if (reset)
      pc <= pcStart;
    else if (done)
      pc <= pc_in ? (ext_out ? ir[7:0] : 8'h00) : pc + 8'd1;
  end

  function automatic logic [17:0] ev(input logic pi, input logic dn, input logic ex,
                                     input logic [3:0] ri, input logic [3:0] ro,
                                     input logic ai, input logic gi, input logic go,
                                     input logic [1:0] alu, input logic bz, input logic hl);
    return {pi, dn, ex, ri, ro, ai, gi, go, alu, bz, hl};
  endfunction

  localparam logic [17:0] V_ZERO  = 18'h0;
  localparam logic [17:0] V_FETCH = 18'h2;

  task automatic applyStimulus(input logic [17:0] vec, input logic chkIr,
                               input logic [15:0] irExp, input string tag);
    exp_t e;
    e.vec = vec; e.chkIr = chkIr; e.irExp = irExp; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic compareVal(input string tag, input logic [17:0] obs, input logic [17:0] expv);
    nCompared++;
    assert (obs === expv) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compareVal(e.tag, obsVec, e.vec);
    if (e.chkIr)
      compareVal({e.tag, "_ir"}, {2'b00, ir}, {2'b00, e.irExp});
  endtask

  task automatic drain();
    while (sb.size() > 0)
      checkOutput();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h165A;
    mem[8'h01] = 16'h3B00;
    mem[8'h02] = 16'h2E00;
    mem[8'h03] = 16'h0000;
    mem[8'h04] = 16'h7123;
    mem[8'h05] = 16'h5020;
    mem[8'h20] = 16'h2500;
    mem[8'h21] = 16'h4100;
    mem[8'h22] = 16'h3000;
    mem[8'h30] = 16'hF000;

    pcStart = 8'h00;
    reset   = 1'b1;
    run     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    compareVal("reset_outputs", obsVec, V_ZERO);
    compareVal("reset_ir", {2'b00, ir}, 18'h0);
    reset = 1'b0;

    applyStimulus(V_FETCH, 1'b0, 16'h0, "load_fetch");
    applyStimulus(ev(0,1,1,4'b0010,4'b0000,0,0,0,2'b00,1,0), 1'b1, 16'h165A, "load_t1");
    drain();
    @(negedge clk); #1;
    compareVal("pc_after_load", {10'h0, pc}, 18'h01);

    applyStimulus(V_FETCH, 1'b0, 16'h0, "add_fetch");
    applyStimulus(ev(0,0,0,4'b0000,4'b0100,1,0,0,2'b00,1,0), 1'b1, 16'h3B00, "add_t1");
    applyStimulus(ev(0,0,0,4'b0000,4'b1000,0,1,0,2'b00,1,0), 1'b0, 16'h0, "add_t2");
    applyStimulus(ev(0,1,0,4'b0100,4'b0000,0,0,1,2'b00,1,0), 1'b0, 16'h0, "add_t3");
    applyStimulus(V_FETCH, 1'b0, 16'h0, "mov_fetch");
    applyStimulus(ev(0,1,0,4'b1000,4'b0100,0,0,0,2'b00,1,0), 1'b1, 16'h2E00, "mov_t1");
    applyStimulus(V_FETCH, 1'b0, 16'h0, "nop_fetch");
    applyStimulus(ev(0,1,0,4'b0000,4'b0000,0,0,0,2'b00,1,0), 1'b1, 16'h0000, "nop_t1");
    applyStimulus(V_FETCH, 1'b0, 16'h0, "ill_fetch");
    applyStimulus(ev(0,1,0,4'b0000,4'b0000,0,0,0,2'b00,1,0), 1'b1, 16'h7123, "ill_t1");
    applyStimulus(V_FETCH, 1'b0, 16'h0, "jmp_fetch");
    applyStimulus(ev(1,1,1,4'b0000,4'b0000,0,0,0,2'b00,1,0), 1'b1, 16'h5020, "jmp_t1");
    drain();
    @(negedge clk); #1;
    compareVal("pc_after_jmp", {10'h0, pc}, 18'h20);

    applyStimulus(V_FETCH, 1'b0, 16'h0, "movsame_fetch");
    applyStimulus(ev(0,1,0,4'b0010,4'b0010,0,0,0,2'b00,1,0), 1'b1, 16'h2500, "movsame_t1");
    applyStimulus(V_FETCH, 1'b0, 16'h0, "sub_fetch");
    applyStimulus(ev(0,0,0,4'b0000,4'b0001,1,0,0,2'b00,1,0), 1'b1, 16'h4100, "sub_t1");
    applyStimulus(ev(0,0,0,4'b0000,4'b0010,0,1,0,2'b01,1,0), 1'b0, 16'h0, "sub_t2");
    drain();
    run = 1'b0;
    applyStimulus(ev(0,1,0,4'b0001,4'b0000,0,0,1,2'b00,1,0), 1'b0, 16'h0, "sub_t3_rundrop");
    applyStimulus(V_ZERO, 1'b0, 16'h0, "idle_1");
    applyStimulus(V_ZERO, 1'b0, 16'h0, "idle_2");
    drain();
    compareVal("pc_after_sub", {10'h0, pc}, 18'h22);

    run = 1'b1;
    applyStimulus(V_FETCH, 1'b0, 16'h0, "addsame_fetch");
    applyStimulus(ev(0,0,0,4'b0000,4'b0001,1,0,0,2'b00,1,0), 1'b1, 16'h3000, "addsame_t1");
    applyStimulus(ev(0,0,0,4'b0000,4'b0001,0,1,0,2'b00,1,0), 1'b0, 16'h0, "addsame_t2");
    drain();
    pcStart = 8'h30;
    #2;
    reset = 1'b1;
    #1;
    compareVal("midreset_outputs", obsVec, V_ZERO);
    compareVal("midreset_ir", {2'b00, ir}, 18'h0);
    @(posedge clk); #1;
    compareVal("midreset_hold", obsVec, V_ZERO);
    reset = 1'b0;

    applyStimulus(V_FETCH, 1'b0, 16'h0, "opf_fetch");
`ifdef HALT_INSTR_EN
    applyStimulus(ev(0,0,0,4'b0000,4'b0000,0,0,0,2'b00,1,0), 1'b1, 16'hF000, "halt_t1");
    for (int i = 0; i < 10; i++)
      applyStimulus(ev(0,0,0,4'b0000,4'b0000,0,0,0,2'b00,1,1), 1'b0, 16'h0, "halt_hold");
    drain();
    compareVal("pc_at_halt", {10'h0, pc}, 18'h30);
`else
    applyStimulus(ev(0,1,0,4'b0000,4'b0000,0,0,0,2'b00,1,0), 1'b1, 16'hF000, "opf_nop_t1");
    applyStimulus(V_FETCH, 1'b0, 16'h0, "after_opf_fetch");
    applyStimulus(ev(0,1,0,4'b0000,4'b0000,0,0,0,2'b00,1,0), 1'b1, 16'h0000, "after_opf_t1");
    drain();
    @(negedge clk); #1;
    compareVal("pc_after_opf", {10'h0, pc}, 18'h32);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Instruction sequencer for the 16-bit bus processor.
- Sequences fetch and execute of each instruction word from program memory.
- Owns the instruction register and drives all datapath strobes: register file in/out, ALU operand/result latches, immediate bus driver, and program counter load/advance (pc_in, done).
- Runs on the same clock as the program counter. The FSM advances on the rising edge; the program counter samples done and pc_in on the following falling edge.

Parameters:
- DATA_W, 16, instruction/bus width; the opcode and field layout below requires 16.
- NUM_REGS, 4, general registers; each is selected by a 2-bit field, so the value is fixed at 4.

Ports:
- clk  in  1  system clock; the FSM and IR update on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- run  in  1  level; sequencer fetches while high.
- instr  in  16  instruction word from program memory at the current PC.
- ir  out  16  latched instruction register (debug/observe).
- pc_in  out  1  PC loads from bus[7:0] instead of incrementing.
- done  out  1  last step of the instruction; enables the PC update.
- ext_out  out  1  drive zero-extended ir[7:0] onto the bus.
- reg_in  out  4  one-hot register write enable.
- reg_out  out  4  one-hot register bus drive.
- a_in  out  1  latch ALU operand A from the bus.
- g_in  out  1  latch ALU result G.
- g_out  out  1  drive G onto the bus.
- alu_op  out  2  00 add, 01 sub; 00 whenever unused.
- busy  out  1  state != IDLE.
- halted  out  1  in HALT state.

Behaviour:
- Instruction format: opcode ir[15:12], rx ir[11:10], ry ir[9:8], imm ir[7:0].
- Opcodes: 0 NOP, 1 LOAD rx<-imm, 2 MOV rx<-ry, 3 ADD rx<-rx+ry, 4 SUB rx<-rx-ry, 5 JMP pc<-imm. 6-E are illegal and execute as NOP. F is defined under Optional Feature.
- States: IDLE, FETCH, T1, T2, T3, HALT. State is held in registers; all outputs except ir are combinational decodes of state and ir.
- Reset (asynchronous):
  - state=IDLE, ir=0.
  - Every output is 0, including busy and halted.
  - A reset mid-instruction aborts it immediately; no done is issued for the aborted instruction.
- IDLE: all strobes 0. If run=1, go to FETCH on the next rising edge.
- FETCH: ir<=instr on the rising edge that leaves FETCH. No strobes asserted. Next state T1.
- T1 by opcode:
  - NOP/illegal: done.
  - LOAD: ext_out, reg_in[rx], done.
  - MOV: reg_out[ry], reg_in[rx], done.
  - ADD/SUB: reg_out[rx], a_in. Next state T2.
  - JMP: ext_out, pc_in, done.
- T2 (ADD/SUB only): reg_out[ry], g_in, alu_op=00 for ADD or 01 for SUB. Next state T3.
- T3 (ADD/SUB only): g_out, reg_in[rx], done.
- After any state with done=1: go to FETCH if run=1, otherwise IDLE. A run drop mid-instruction finishes the current instruction first.
- Latency in cycles, FETCH included: NOP/LOAD/MOV/JMP 2, ADD/SUB 4. Back-to-back throughput matches this latency; there are no bubbles.
- done is high for exactly one cycle per completed instruction. pc_in is only ever high together with done.
- Bus drivers: at most one of ext_out, g_out, or any reg_out bit is high in any cycle.
- reg_in and reg_out are each zero or one-hot.
- MOV with rx==ry is legal: reg_out and reg_in hit the same register, with no special case.
- ADD/SUB with rx==ry is legal and computes rx+rx or rx-rx.

Optional Feature:
- Macro: HALT_INSTR_EN.
- Defined: opcode F asserts no strobes and no done in T1, then goes to HALT. HALT is absorbing until reset: halted=1, busy=1, all strobes 0, run ignored. PC stays at the HALT instruction address.
- Undefined: opcode F behaves as NOP, the HALT state does not exist, and halted is tied 0.

Test Plan:
- Reset asserted mid-cycle with run=1 -> all outputs 0 immediately, ir=0000. After release, FETCH occurs on the first rising edge.
- run=1, instr=0x165A (LOAD r1,0x5A) -> FETCH, then T1 with ext_out=1, reg_in=0010, done=1; pc advances by 1 on that falling edge.
- instr=0x3B00 (ADD r2,r3) -> T1 reg_out=0100, a_in=1. T2 reg_out=1000, g_in=1, alu_op=00. T3 g_out=1, reg_in=0100, done=1. Four cycles total.
- instr=0x5020 (JMP 0x20) -> T1 ext_out=1, pc_in=1, done=1. Next fetch comes from address 0x20.
- run dropped during T2 of SUB 0x4100 -> T3 completes with done=1, then IDLE, busy=0. Reset asserted in T2 instead -> IDLE with no done.
- HALT_INSTR_EN defined, instr=0xF000 -> HALT with halted=1, no done, stays there with run=1 for 10 cycles. Macro undefined -> behaves as NOP with done=1.
